// File: rtl/svm_sched_pkg.sv
// Shared scheduler types and widths used by the dependency tracker and its helpers.
package svm_sched_pkg;

  localparam int OWNER_ID_W                 = 64;
  localparam int DEFAULT_MAX_DEPENDENCIES   = 256;
  localparam int DEFAULT_MAX_ACTIVE_BATCHES = 4;

  typedef struct packed {
    logic raw;
    logic waw;
    logic war;
  } conflict_flags_t;

endpackage

// File: rtl/dep_slot_alloc.sv
// Lowest-index free slot finder over the slot-table valid mask.
module dep_slot_alloc #(
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] valid_mask,
  output logic [SLOT_W-1:0]    free_slot,
  output logic                 any_free
);

  // Scan downwards so the last hit (lowest index) wins; index 0 when full.
  always_comb begin
    free_slot = '0;
    any_free  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) begin
        free_slot = SLOT_W'(i);
        any_free  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dependency_tracker.sv
// Slot table of in-flight batch dependency sets with registered RAW/WAW/WAR
// conflict queries and aggregate locked read/write sets.
module dependency_tracker
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES   = DEFAULT_MAX_DEPENDENCIES,
  parameter int MAX_ACTIVE_BATCHES = DEFAULT_MAX_ACTIVE_BATCHES,
  localparam int SLOT_W            = $clog2(MAX_ACTIVE_BATCHES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        new_batch_valid,
  output logic                        new_batch_ready,
  input  logic [MAX_DEPENDENCIES-1:0] batch_read_deps_union,
  input  logic [MAX_DEPENDENCIES-1:0] batch_write_deps_union,
  input  logic [OWNER_ID_W-1:0]       batch_owner_id,
  output logic [SLOT_W-1:0]           alloc_slot,
  input  logic                        retire_valid,
  input  logic [SLOT_W-1:0]           retire_slot,
  output logic                        retire_error,
  input  logic                        query_valid,
  input  logic [MAX_DEPENDENCIES-1:0] query_read_deps,
  input  logic [MAX_DEPENDENCIES-1:0] query_write_deps,
  input  logic [OWNER_ID_W-1:0]       query_owner_id,
  output logic                        query_resp_valid,
  output logic                        query_conflict,
  output logic                        query_raw,
  output logic                        query_waw,
  output logic                        query_war,
  output logic [SLOT_W:0]             active_count,
  output logic [MAX_DEPENDENCIES-1:0] locked_read_deps,
  output logic [MAX_DEPENDENCIES-1:0] locked_write_deps,
  output logic [31:0]                 batches_registered,
  output logic [31:0]                 batches_retired
);

  localparam int N = MAX_ACTIVE_BATCHES;

  logic [N-1:0]                valid_q, valid_d;
  logic [MAX_DEPENDENCIES-1:0] read_q  [N];
  logic [MAX_DEPENDENCIES-1:0] read_d  [N];
  logic [MAX_DEPENDENCIES-1:0] write_q [N];
  logic [MAX_DEPENDENCIES-1:0] write_d [N];
  logic [OWNER_ID_W-1:0]       owner_q [N];
  logic [OWNER_ID_W-1:0]       owner_d [N];

  logic                        resp_valid_q, resp_valid_d;
  conflict_flags_t             flags_q, flags_d;
  logic                        retire_error_q, retire_error_d;
  logic [SLOT_W:0]             active_count_q, active_count_d;
  logic [MAX_DEPENDENCIES-1:0] locked_read_q, locked_read_d;
  logic [MAX_DEPENDENCIES-1:0] locked_write_q, locked_write_d;
  logic [31:0]                 registered_q, registered_d;
  logic [31:0]                 retired_q, retired_d;

  logic        accept;
  logic        retire_ok;
  logic [N-1:0] slot_raw, slot_waw, slot_war;

  dep_slot_alloc #(.NUM_SLOTS(N)) u_alloc (
    .valid_mask (valid_q),
    .free_slot  (alloc_slot),
    .any_free   (new_batch_ready)
  );

  assign accept    = new_batch_valid && new_batch_ready;
  assign retire_ok = retire_valid && valid_q[retire_slot];

  // A batch never conflicts with itself, so same-owner slots are masked out.
  for (genvar g = 0; g < N; g++) begin : g_slot
    logic live;
    assign live        = valid_q[g] && (owner_q[g] != query_owner_id);
    assign slot_raw[g] = live && |(query_read_deps  & write_q[g]);
    assign slot_waw[g] = live && |(query_write_deps & write_q[g]);
    assign slot_war[g] = live && |(query_write_deps & read_q[g]);
  end

  always_comb begin
    valid_d = valid_q;
    read_d  = read_q;
    write_d = write_q;
    owner_d = owner_q;
    if (retire_ok) begin
      valid_d[retire_slot] = 1'b0;
    end
    if (accept) begin
      valid_d[alloc_slot] = 1'b1;
      read_d[alloc_slot]  = batch_read_deps_union;
      write_d[alloc_slot] = batch_write_deps_union;
      owner_d[alloc_slot] = batch_owner_id;
    end

    resp_valid_d = query_valid;
    flags_d      = '0;
    if (query_valid) begin
      flags_d.raw = |slot_raw;
      flags_d.waw = |slot_waw;
      flags_d.war = |slot_war;
    end

    retire_error_d = retire_valid && !valid_q[retire_slot];
    registered_d   = registered_q + 32'(accept);
    retired_d      = retired_q + 32'(retire_ok);

    // Aggregates are built from the next table so they land with the update.
    active_count_d = '0;
    locked_read_d  = '0;
    locked_write_d = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_d[i]) begin
        active_count_d = active_count_d + 1'b1;
        locked_read_d  = locked_read_d  | read_d[i];
        locked_write_d = locked_write_d | write_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q        <= '0;
      resp_valid_q   <= 1'b0;
      flags_q        <= '0;
      retire_error_q <= 1'b0;
      active_count_q <= '0;
      locked_read_q  <= '0;
      locked_write_q <= '0;
      registered_q   <= '0;
      retired_q      <= '0;
    end else begin
      valid_q        <= valid_d;
      resp_valid_q   <= resp_valid_d;
      flags_q        <= flags_d;
      retire_error_q <= retire_error_d;
      active_count_q <= active_count_d;
      locked_read_q  <= locked_read_d;
      locked_write_q <= locked_write_d;
      registered_q   <= registered_d;
      retired_q      <= retired_d;
    end
  end

  // Slot contents are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    read_q  <= read_d;
    write_q <= write_d;
    owner_q <= owner_d;
  end

  assign query_resp_valid   = resp_valid_q;
  assign query_raw          = flags_q.raw;
  assign query_waw          = flags_q.waw;
  assign query_war          = flags_q.war;
  assign query_conflict     = flags_q.raw | flags_q.waw | flags_q.war;
  assign retire_error       = retire_error_q;
  assign active_count       = active_count_q;
  assign locked_read_deps   = locked_read_q;
  assign locked_write_deps  = locked_write_q;
  assign batches_registered = registered_q;
  assign batches_retired    = retired_q;

endmodule

// File: tb/tb_dependency_tracker.sv
// Directed self-checking bench for dependency_tracker with hand-computed expectations.
module tb_dependency_tracker;

  localparam int D = 256;

  logic          clk;
  logic          rst_n;
  logic          new_batch_valid;
  logic          new_batch_ready;
  logic [D-1:0]  batch_read_deps_union;
  logic [D-1:0]  batch_write_deps_union;
  logic [63:0]   batch_owner_id;
  logic [1:0]    alloc_slot;
  logic          retire_valid;
  logic [1:0]    retire_slot;
  logic          retire_error;
  logic          query_valid;
  logic [D-1:0]  query_read_deps;
  logic [D-1:0]  query_write_deps;
  logic [63:0]   query_owner_id;
  logic          query_resp_valid;
  logic          query_conflict;
  logic          query_raw;
  logic          query_waw;
  logic          query_war;
  logic [2:0]    active_count;
  logic [D-1:0]  locked_read_deps;
  logic [D-1:0]  locked_write_deps;
  logic [31:0]   batches_registered;
  logic [31:0]   batches_retired;

  int checks = 0;
  int errors = 0;

  dependency_tracker dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .new_batch_valid        (new_batch_valid),
    .new_batch_ready        (new_batch_ready),
    .batch_read_deps_union  (batch_read_deps_union),
    .batch_write_deps_union (batch_write_deps_union),
    .batch_owner_id         (batch_owner_id),
    .alloc_slot             (alloc_slot),
    .retire_valid           (retire_valid),
    .retire_slot            (retire_slot),
    .retire_error           (retire_error),
    .query_valid            (query_valid),
    .query_read_deps        (query_read_deps),
    .query_write_deps       (query_write_deps),
    .query_owner_id         (query_owner_id),
    .query_resp_valid       (query_resp_valid),
    .query_conflict         (query_conflict),
    .query_raw              (query_raw),
    .query_waw              (query_waw),
    .query_war              (query_war),
    .active_count           (active_count),
    .locked_read_deps       (locked_read_deps),
    .locked_write_deps      (locked_write_deps),
    .batches_registered     (batches_registered),
    .batches_retired        (batches_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    new_batch_valid        = 1'b0;
    batch_read_deps_union  = '0;
    batch_write_deps_union = '0;
    batch_owner_id         = '0;
    retire_valid           = 1'b0;
    retire_slot            = '0;
    query_valid            = 1'b0;
    query_read_deps        = '0;
    query_write_deps       = '0;
    query_owner_id         = '0;
  endtask

  task automatic drive_batch(input logic [D-1:0] r, input logic [D-1:0] w, input logic [63:0] o);
    new_batch_valid        = 1'b1;
    batch_read_deps_union  = r;
    batch_write_deps_union = w;
    batch_owner_id         = o;
  endtask

  task automatic do_query(input logic [D-1:0] r, input logic [D-1:0] w, input logic [63:0] o);
    query_valid      = 1'b1;
    query_read_deps  = r;
    query_write_deps = w;
    query_owner_id   = o;
    tick();
    query_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (new_batch_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b expected 1", new_batch_ready); end
    checks++; if (alloc_slot !== 2'd0) begin errors++; $display("[TB] FAIL reset_alloc: got %0d expected 0", alloc_slot); end
    checks++; if (active_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_active: got %0d expected 0", active_count); end
    checks++; if (locked_read_deps !== '0 || locked_write_deps !== '0) begin errors++; $display("[TB] FAIL reset_locked: got r=%h w=%h expected 0", locked_read_deps, locked_write_deps); end
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war, retire_error} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {query_resp_valid, query_conflict, query_raw, query_waw, query_war, retire_error}); end
    checks++; if (batches_registered !== 32'd0 || batches_retired !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", batches_registered, batches_retired); end
  endtask

  task automatic test_register();
    drive_batch(256'h1, 256'h2, 64'd5);
    checks++; if (alloc_slot !== 2'd0) begin errors++; $display("[TB] FAIL reg_alloc: got %0d expected 0", alloc_slot); end
    tick();
    new_batch_valid = 1'b0;
    checks++; if (active_count !== 3'd1) begin errors++; $display("[TB] FAIL reg_active: got %0d expected 1", active_count); end
    checks++; if (locked_read_deps !== 256'h1) begin errors++; $display("[TB] FAIL reg_locked_read: got %h expected 1", locked_read_deps); end
    checks++; if (locked_write_deps !== 256'h2) begin errors++; $display("[TB] FAIL reg_locked_write: got %h expected 2", locked_write_deps); end
    checks++; if (batches_registered !== 32'd1) begin errors++; $display("[TB] FAIL reg_count: got %0d expected 1", batches_registered); end
    checks++; if (alloc_slot !== 2'd1) begin errors++; $display("[TB] FAIL reg_next_alloc: got %0d expected 1", alloc_slot); end
  endtask

  task automatic test_query();
    do_query(256'h2, 256'h0, 64'd7);
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b11100) begin errors++; $display("[TB] FAIL q_raw: got %b expected 11100", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
    tick();
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b00000) begin errors++; $display("[TB] FAIL q_idle: got %b expected 00000", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
    do_query(256'h2, 256'h0, 64'd5);
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b10000) begin errors++; $display("[TB] FAIL q_same_owner: got %b expected 10000", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
    do_query(256'h0, 256'h1, 64'd7);
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b11001) begin errors++; $display("[TB] FAIL q_war: got %b expected 11001", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
    do_query(256'h0, 256'h2, 64'd7);
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b11010) begin errors++; $display("[TB] FAIL q_waw: got %b expected 11010", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
    do_query(256'h100, 256'h100, 64'd7);
    checks++; if ({query_resp_valid, query_conflict, query_raw, query_waw, query_war} !== 5'b10000) begin errors++; $display("[TB] FAIL q_disjoint: got %b expected 10000", {query_resp_valid, query_conflict, query_raw, query_waw, query_war}); end
  endtask

  task automatic test_back_to_back_fill();
    logic [D-1:0] rd [3];
    logic [D-1:0] wr [3];
    rd[0] = 256'h10;  wr[0] = 256'h20;
    rd[1] = 256'h40;  wr[1] = 256'h80;
    rd[2] = 256'h400; wr[2] = 256'h800;
    for (int i = 0; i < 3; i++) begin
      drive_batch(rd[i], wr[i], 64'(i + 1));
      checks++; if (alloc_slot !== 2'(i + 1)) begin errors++; $display("[TB] FAIL fill_alloc%0d: got %0d expected %0d", i, alloc_slot, i + 1); end
      tick();
    end
    new_batch_valid = 1'b0;
    checks++; if (new_batch_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %0b expected 0", new_batch_ready); end
    checks++; if (active_count !== 3'd4) begin errors++; $display("[TB] FAIL full_active: got %0d expected 4", active_count); end
    checks++; if (locked_read_deps !== 256'h451 || locked_write_deps !== 256'h8a2) begin errors++; $display("[TB] FAIL full_locked: got r=%h w=%h expected r=451 w=8a2", locked_read_deps, locked_write_deps); end
    do_query(256'h800, 256'h0, 64'd7);
    checks++; if ({query_conflict, query_raw, query_waw, query_war} !== 4'b1100) begin errors++; $display("[TB] FAIL full_query_slot3: got %b expected 1100", {query_conflict, query_raw, query_waw, query_war}); end
  endtask

  task automatic test_retire_while_full();
    drive_batch(256'h1000, 256'h2000, 64'd9);
    retire_valid = 1'b1;
    retire_slot  = 2'd2;
    checks++; if (new_batch_ready !== 1'b0) begin errors++; $display("[TB] FAIL held_ready: got %0b expected 0", new_batch_ready); end
    tick();
    retire_valid = 1'b0;
    checks++; if (new_batch_ready !== 1'b1 || alloc_slot !== 2'd2) begin errors++; $display("[TB] FAIL retired_alloc: got ready=%0b slot=%0d expected ready=1 slot=2", new_batch_ready, alloc_slot); end
    checks++; if (batches_retired !== 32'd1 || batches_registered !== 32'd4) begin errors++; $display("[TB] FAIL retired_counts: got %0d/%0d expected reg=4 ret=1", batches_registered, batches_retired); end
    checks++; if (active_count !== 3'd3) begin errors++; $display("[TB] FAIL retired_active: got %0d expected 3", active_count); end
    tick();
    new_batch_valid = 1'b0;
    checks++; if (active_count !== 3'd4 || batches_registered !== 32'd5 || new_batch_ready !== 1'b0) begin errors++; $display("[TB] FAIL refill: got active=%0d reg=%0d ready=%0b expected 4/5/0", active_count, batches_registered, new_batch_ready); end
    checks++; if (locked_read_deps !== 256'h1411) begin errors++; $display("[TB] FAIL refill_locked: got %h expected 1411", locked_read_deps); end
  endtask

  task automatic test_retire_error();
    retire_valid = 1'b1;
    retire_slot  = 2'd3;
    tick();
    checks++; if (retire_error !== 1'b0 || batches_retired !== 32'd2) begin errors++; $display("[TB] FAIL retire3_ok: got err=%0b ret=%0d expected 0/2", retire_error, batches_retired); end
    tick();
    retire_valid = 1'b0;
    checks++; if (retire_error !== 1'b1) begin errors++; $display("[TB] FAIL retire_err_pulse: got %0b expected 1", retire_error); end
    checks++; if (batches_retired !== 32'd2 || active_count !== 3'd3) begin errors++; $display("[TB] FAIL retire_err_counts: got ret=%0d active=%0d expected 2/3", batches_retired, active_count); end
    tick();
    checks++; if (retire_error !== 1'b0) begin errors++; $display("[TB] FAIL retire_err_once: got %0b expected 0", retire_error); end
  endtask

  task automatic test_register_and_retire();
    drive_batch(256'h4000, 256'h8000, 64'd4);
    retire_valid = 1'b1;
    retire_slot  = 2'd0;
    checks++; if (alloc_slot !== 2'd3) begin errors++; $display("[TB] FAIL both_alloc: got %0d expected 3", alloc_slot); end
    tick();
    clear_inputs();
    checks++; if (active_count !== 3'd3) begin errors++; $display("[TB] FAIL both_active: got %0d expected 3", active_count); end
    checks++; if (batches_registered !== 32'd6 || batches_retired !== 32'd3) begin errors++; $display("[TB] FAIL both_counts: got %0d/%0d expected 6/3", batches_registered, batches_retired); end
    checks++; if (alloc_slot !== 2'd0 || new_batch_ready !== 1'b1) begin errors++; $display("[TB] FAIL both_free0: got slot=%0d ready=%0b expected 0/1", alloc_slot, new_batch_ready); end
    checks++; if (locked_read_deps !== 256'h5010 || locked_write_deps !== 256'ha020) begin errors++; $display("[TB] FAIL both_locked: got r=%h w=%h expected r=5010 w=a020", locked_read_deps, locked_write_deps); end
  endtask

  task automatic test_reset_mid();
    query_valid     = 1'b1;
    query_write_deps = 256'h4000;
    query_owner_id  = 64'd7;
    rst_n = 1'b0;
    tick();
    clear_inputs();
    checks++; if (new_batch_ready !== 1'b1 || alloc_slot !== 2'd0 || active_count !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_table: got ready=%0b slot=%0d active=%0d expected 1/0/0", new_batch_ready, alloc_slot, active_count); end
    checks++; if (locked_read_deps !== '0 || locked_write_deps !== '0) begin errors++; $display("[TB] FAIL mid_reset_locked: got r=%h w=%h expected 0", locked_read_deps, locked_write_deps); end
    checks++; if ({query_resp_valid, query_conflict, retire_error} !== 3'b000 || batches_registered !== 32'd0 || batches_retired !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_misc: got flags=%b reg=%0d ret=%0d expected 000/0/0", {query_resp_valid, query_conflict, retire_error}, batches_registered, batches_retired); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_register();
    test_query();
    test_back_to_back_fill();
    test_retire_while_full();
    test_retire_error();
    test_register_and_retire();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dependency_tracker.md
# dependency_tracker

Global dependency manager at the consumer end of the batcher's batch-registration interface. Accepts each completed batch's read/write dependency unions and owner ID into a slot table, holds them while the batch executes, and frees the slot on retirement from the execution side. Answers single-cycle-issue conflict queries (RAW/WAW/WAR) for candidate transactions against all in-flight batches. Exports the aggregate locked read/write sets.

## Interface
- MAX_DEPENDENCIES, 256, dependency vector width
- MAX_ACTIVE_BATCHES, 4, slot table depth; power of two, ≥2; SLOT_W = $clog2(MAX_ACTIVE_BATCHES)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- new_batch_valid  in  1  registration request
- new_batch_ready  out  1  high when ≥1 free slot
- batch_read_deps_union  in  MAX_DEPENDENCIES  batch read set
- batch_write_deps_union  in  MAX_DEPENDENCIES  batch write set
- batch_owner_id  in  64  batch owner
- alloc_slot  out  SLOT_W  slot taken by this handshake (valid while new_batch_valid && new_batch_ready)
- retire_valid  in  1  batch finished execution
- retire_slot  in  SLOT_W  slot to free
- retire_error  out  1  one-cycle pulse: retire of a free slot
- query_valid  in  1  conflict query
- query_read_deps / query_write_deps  in  MAX_DEPENDENCIES each  candidate sets
- query_owner_id  in  64  candidate owner
- query_resp_valid  out  1  response strobe
- query_conflict, query_raw, query_waw, query_war  out  1 each  response flags
- active_count  out  SLOT_W+1  occupied slots
- locked_read_deps / locked_write_deps  out  MAX_DEPENDENCIES each  OR over occupied slots
- batches_registered / batches_retired  out  32 each  event counters

## Operation
- Slot table: valid bit, read set, write set, owner per slot.
- Register: on new_batch_valid && new_batch_ready, write inputs into lowest-index free slot; alloc_slot = that index (combinational, from registered valid mask).
- Retire: on retire_valid with slot valid, clear valid bit (contents don't-care). Slot free → ignore, pulse retire_error next cycle.
- Query (against occupied slots whose owner ≠ query_owner_id): raw = |(q_read & slot_write); waw = |(q_write & slot_write); war = |(q_write & slot_read); OR across slots; query_conflict = raw|waw|war.
- Counters: +1 per accepted registration / per valid retire; wrap at 2^32.
- active_count = popcount(valid mask).

## Timing
- Reset: all valid bits 0; new_batch_ready=1; alloc_slot=0; active_count=0; locked_*=0; query_resp_valid and all flags 0; retire_error=0; counters 0. Reset mid-operation discards all slots in one cycle.
- new_batch_ready, alloc_slot: combinational from registered state; no dependence on retire_valid in the same cycle. A retire does not make a slot reusable until the next cycle.
- Table full: new_batch_ready=0; request held; registration occurs the cycle after a retire.
- Query latency 1: flags registered, query_resp_valid high exactly the cycle after query_valid; flags 0 when no query.
- Queries, locked_*, and active_count see the table state at the start of the cycle. Same-cycle register/retire take effect the next cycle.
- Register + retire in the same cycle: both applied, on different slots by construction. active_count is unchanged.
- locked_*, active_count: registered, reflect table one cycle after update.

## Structure
- Shared package svm_sched_pkg: OWNER_ID_W=64, conflict-flag struct {raw,waw,war}, default MAX_DEPENDENCIES.
- Sub-module dep_slot_alloc: lowest-free-slot priority encoder plus any-free flag from the valid mask.
- Per-slot conflict reduction in a generate loop; no extra module.

## Test plan
- Reset, then register read=0x1, write=0x2, owner=5 → alloc_slot=0, next cycle active_count=1, locked_read=0x1, locked_write=0x2, batches_registered=1.
- Query read=0x2, write=0x0, owner=7 → next cycle raw=1, waw=0, war=0, conflict=1. Same query with owner=5 → all flags 0.
- Query write=0x1, owner=7 → war=1. Query write=0x2 → waw=1. Disjoint sets 0x100 → conflict=0.
- Fill 4 slots → new_batch_ready=0, active_count=4. Retire slot 2 with a new request pending → ready=1 next cycle, alloc_slot=2, batches_retired=1.
- Retire slot 3 while empty → retire_error pulses once, counters unchanged. Simultaneous register and retire of slot 0 → active_count unchanged.
- Assert rst_n=0 with 3 slots occupied → next cycle all outputs at reset values, new_batch_ready=1.
